vga_scan_out: RTL and testbench

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 108 ++++++++++
 tb/tb_vga_scan_out.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// VGA scan-out engine: raster counters, 4x-replicated frame-buffer addressing,
// sync/blank pipeline matched to the frame-buffer read latency, swap pulse.
module vga_scan_out #(
   parameter int unsigned RD_LAT       = 3,
   parameter int unsigned H_TOTAL      = 800,
   parameter int unsigned V_TOTAL      = 525,
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_SYNC_START = 656,
   parameter int unsigned H_SYNC_END   = 752,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_SYNC_START = 490,
   parameter int unsigned V_SYNC_END   = 492
) (
   input  logic        clk,
   input  logic        rst,
   output logic [14:0] read_address,
   input  logic [23:0] read_data,
   output logic        disp_done,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   localparam int unsigned HW     = $clog2(H_TOTAL);
   localparam int unsigned VW     = $clog2(V_TOTAL);
   localparam int unsigned AW     = 15;
   localparam int unsigned DEPTH  = RD_LAT + 2;
   localparam int unsigned STRIDE = H_ACTIVE / 4;

   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   logic             h_last_c;
   logic             v_last_c;
   logic             active_c;
   logic             hs_n_c;
   logic             vs_n_c;
   logic [AW-1:0]    addr_c;
   logic [DEPTH-1:0] act_pipe;
   logic [DEPTH-1:0] hs_pipe;
   logic [DEPTH-1:0] vs_pipe;

   // Raster position decode
   always_comb begin
      h_last_c = (h_cnt == HW'(H_TOTAL - 1));
      v_last_c = (v_cnt == VW'(V_TOTAL - 1));
      active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
      hs_n_c   = !((h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END)));
      vs_n_c   = !((v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END)));
      addr_c   = AW'(v_cnt >> 2) * AW'(STRIDE) + AW'(h_cnt >> 2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_last_c ? '0 : h_cnt + HW'(1);
         if (h_last_c) begin
            v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
         end
      end
   end

   // Address and swap pulse; disp_done is high while the counters sit at (0, V_ACTIVE)
   always_ff @(posedge clk) begin
      if (rst) begin
         read_address <= '0;
         disp_done    <= 1'b0;
      end else begin
         read_address <= active_c ? addr_c : '0;
         disp_done    <= h_last_c && (v_cnt == VW'(V_ACTIVE - 1));
      end
   end

   // Timing pipeline; sync stages hold the active-low level so reset means idle
   always_ff @(posedge clk) begin
      if (rst) begin
         act_pipe <= '0;
         hs_pipe  <= '1;
         vs_pipe  <= '1;
      end else begin
         act_pipe <= {act_pipe[DEPTH-2:0], active_c};
         hs_pipe  <= {hs_pipe[DEPTH-2:0], hs_n_c};
         vs_pipe  <= {vs_pipe[DEPTH-2:0], vs_n_c};
      end
   end

   // Colour captured one stage before the blank output so both land together
   always_ff @(posedge clk) begin
      if (rst) begin
         {vga_r, vga_g, vga_b} <= '0;
      end else if (act_pipe[DEPTH-2]) begin
         {vga_r, vga_g, vga_b} <= read_data;
      end else begin
         {vga_r, vga_g, vga_b} <= '0;
      end
   end

   assign vga_hs      = hs_pipe[DEPTH-1];
   assign vga_vs      = vs_pipe[DEPTH-1];
   assign vga_blank_n = act_pipe[DEPTH-1];
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out: full-width lines, shortened frame height,
// 3-cycle RAM model returning the address so pixel data is predictable.
module tb_vga_scan_out;

   logic        clk;
   logic        rst;
   logic [14:0] read_address;
   logic [23:0] read_data;
   logic        disp_done;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        vga_sync_n;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;

   logic [14:0] p0;
   logic [14:0] p1;
   logic [23:0] bias;

   int n_cmp  = 0;
   int n_fail = 0;
   int t      = 0;
   int dd_count = 0;

   vga_scan_out #(
      .RD_LAT(3), .H_TOTAL(800), .V_TOTAL(18),
      .H_ACTIVE(640), .H_SYNC_START(656), .H_SYNC_END(752),
      .V_ACTIVE(12), .V_SYNC_START(14), .V_SYNC_END(16)
   ) dut (
      .clk(clk), .rst(rst), .read_address(read_address), .read_data(read_data),
      .disp_done(disp_done), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame buffer with 3-cycle read latency
   always @(posedge clk) begin
      p0        <= read_address;
      p1        <= p0;
      read_data <= {9'b0, p1} | bias;
   end

   always @(negedge clk) begin
      if (disp_done === 1'b1) dd_count <= dd_count + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
      t += n;
   endtask

   task automatic goto(input int target);
      if (target > t) tick(target - t);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_addr"}, 32'(read_address), 32'd0);
      chk({tag, "_dd"},   32'(disp_done),    32'd0);
      chk({tag, "_hs"},   32'(vga_hs),       32'd1);
      chk({tag, "_vs"},   32'(vga_vs),       32'd1);
      chk({tag, "_blk"},  32'(vga_blank_n),  32'd0);
      chk({tag, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'd0);
      chk({tag, "_syn"},  32'(vga_sync_n),   32'd0);
   endtask

   initial begin
      int blank_cnt;
      int hs_low_cnt;
      int hs_fall;
      logic hs_prev;

      rst  = 1'b1;
      bias = '0;
      tick(3);
      chk_reset_state("reset");
      rst = 1'b0;
      t   = 0;

      goto(4);
      chk("addr_t4", 32'(read_address), 32'd0);
      chk("blank_t4", 32'(vga_blank_n), 32'd0);
      goto(5);
      chk("addr_x4y0", 32'(read_address), 32'd1);
      chk("blank_t5", 32'(vga_blank_n), 32'd1);

      // One full line of output starting at the first visible pixel
      blank_cnt = 0; hs_low_cnt = 0; hs_fall = -1; hs_prev = vga_hs;
      for (int i = 0; i < 800; i++) begin
         if (vga_blank_n === 1'b1) blank_cnt++;
         if (vga_hs === 1'b0) hs_low_cnt++;
         if (hs_prev === 1'b1 && vga_hs === 1'b0 && hs_fall < 0) hs_fall = t;
         hs_prev = vga_hs;
         tick(1);
      end
      chk("blank_per_line", 32'(blank_cnt), 32'd640);
      chk("hs_low_width", 32'(hs_low_cnt), 32'd96);
      chk("hs_fall_time", 32'(hs_fall), 32'd661);

      goto(1441);  chk("addr_hblank", 32'(read_address), 32'd0);
      goto(1460);  chk("hs_l1_pre", 32'(vga_hs), 32'd1);
      goto(1461);  chk("hs_l1_fall", 32'(vga_hs), 32'd0);
      goto(3201);  chk("addr_x0y4", 32'(read_address), 32'd160);
      goto(3213);
      chk("pix84_b", 32'(vga_b), 32'd162);
      chk("pix84_g", 32'(vga_g), 32'd0);
      chk("pix84_r", 32'(vga_r), 32'd0);
      goto(3905);
      chk("hblank_blk", 32'(vga_blank_n), 32'd0);
      chk("hblank_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      goto(9440);  chk("addr_last", 32'(read_address), 32'd479);
      goto(9444);
      chk("pix_last_b", 32'(vga_b), 32'd223);
      chk("pix_last_g", 32'(vga_g), 32'd1);
      goto(9599);  chk("dd_pre", 32'(disp_done), 32'd0);
      goto(9600);  chk("dd_first", 32'(disp_done), 32'd1);
      goto(9601);
      chk("dd_post", 32'(disp_done), 32'd0);
      chk("dd_count1", 32'(dd_count), 32'd1);
      chk("addr_vblank", 32'(read_address), 32'd0);

      goto(11204); chk("vs_pre", 32'(vga_vs), 32'd1);
      goto(11205); chk("vs_fall", 32'(vga_vs), 32'd0);
      goto(12804); chk("vs_last_low", 32'(vga_vs), 32'd0);
      goto(12805); chk("vs_rise", 32'(vga_vs), 32'd1);

      // Nonzero red on every read exposes any leak of data into blanking
      goto(13000); bias = 24'hC30000;
      goto(13500);
      chk("vblank_r", 32'(vga_r), 32'd0);
      chk("vblank_blk", 32'(vga_blank_n), 32'd0);
      goto(17613);
      chk("f2_pix84_r", 32'(vga_r), 32'hC3);
      chk("f2_pix84_b", 32'(vga_b), 32'd162);
      goto(18305);
      chk("f2_hblank_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);

      goto(23999); chk("dd2_pre", 32'(disp_done), 32'd0);
      goto(24000); chk("dd2", 32'(disp_done), 32'd1);
      goto(24001);
      chk("dd2_post", 32'(disp_done), 32'd0);
      chk("dd_count2", 32'(dd_count), 32'd2);
      goto(25604); chk("vs2_pre", 32'(vga_vs), 32'd1);
      goto(25605); chk("vs2_fall", 32'(vga_vs), 32'd0);
      bias = '0;

      // Mid-frame reset at (300,5) of the third frame
      goto(33100);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      t   = 0;
      chk_reset_state("midrst");

      goto(5);
      chk("rs_addr", 32'(read_address), 32'd1);
      chk("rs_blank", 32'(vga_blank_n), 32'd1);
      goto(660);   chk("rs_hs_pre", 32'(vga_hs), 32'd1);
      goto(661);   chk("rs_hs_fall", 32'(vga_hs), 32'd0);
      goto(756);   chk("rs_hs_low", 32'(vga_hs), 32'd0);
      goto(757);   chk("rs_hs_rise", 32'(vga_hs), 32'd1);
      goto(9599);  chk("rs_no_abort_dd", 32'(dd_count), 32'd2);
      goto(9600);  chk("rs_dd", 32'(disp_done), 32'd1);
      goto(9601);  chk("rs_dd_count", 32'(dd_count), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
